instruction_memory: RTL and testbench

- Program store of the 8-bit CPU; fetch stage drives the program counter and receives the 16-bit instruction word combinationally.
- Holds DEPTH words, initialised to a fixed boot program.
- Includes a synchronous load port so a test harness or boot loader can overwrite words.
- Asynchronous active-low reset restores the boot program.

---
 rtl/instruction_memory.sv | 84 ++++++++
 tb/tb_instruction_memory.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
//
// Program store for the 8-bit CPU. Holds DEPTH 16-bit instruction words that
// reset to a fixed boot program. The fetch stage reads the word at pc with
// zero latency. A synchronous load port lets a boot loader or test harness
// overwrite words.
//
// Ports:
//   clk                  system clock; load-port writes on the rising edge
//   rst_n                asynchronous active-low reset, restores boot image
//   pc                   fetch address
//   current_instruction  word at pc, or NOP_WORD when pc >= DEPTH
//   wr_en                load-port write enable, active high
//   wr_addr              load-port word address
//   wr_data              load-port write data
// ---------------------------------------------------------------------------
module instruction_memory #(
    parameter int          DEPTH    = 10,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pc,
    output logic [15:0] current_instruction,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data
);

    // Index width for the storage array; at least one bit so DEPTH=1 works.
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Nine bits so DEPTH=256 is representable in the range compares.
    localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

    logic [15:0] mem [DEPTH];

    logic pc_in_range;
    logic wr_in_range;

    // Boot program; anything past the image resets to NOP_WORD.
    function automatic logic [15:0] boot_word(input int idx);
        logic [15:0] w;
        case (idx)
            0:       w = 16'h1105;
            1:       w = 16'h1203;
            2:       w = 16'h3312;
            3:       w = 16'h4430;
            4:       w = 16'h5140;
            5:       w = 16'h6200;
            6:       w = 16'h7105;
            7:       w = 16'h8008;
            8:       w = 16'h9000;
            9:       w = 16'hF000;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    assign pc_in_range = ({1'b0, pc} < DEPTH_W);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);

    // Out-of-range writes are dropped rather than truncated onto low words,
    // which is why the index is only taken after the range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= boot_word(i);
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Combinational fetch; unimplemented addresses read as NOP so the output
    // is never X for any pc.
    always_comb begin
        current_instruction = NOP_WORD;
        if (pc_in_range) begin
            current_instruction = mem[pc[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// ---------------------------------------------------------------------------
// tb_instruction_memory
//
// Self-checking bench for instruction_memory (DEPTH=10). A 256-entry
// reference array models the full 8-bit address space: boot image on reset,
// writes land only below DEPTH, everything else reads NOP.
// ---------------------------------------------------------------------------
module tb_instruction_memory;

    localparam int          DEPTH = 10;
    localparam logic [15:0] NOP   = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [15:0] current_instruction;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [256];
    logic [15:0] boot  [10];

    instruction_memory #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc                  (pc),
        .current_instruction (current_instruction),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int a = 0; a < 256; a++) begin
            model[a] = (a < DEPTH) ? boot[a] : NOP;
        end
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
        if (int'(a) < DEPTH) model[a] = d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int a = 0; a < 3; a++) begin
            pc = 8'(a);
            #10;
            n_checks++;
            if (current_instruction !== model[a]) begin
                n_fail++;
                $display("FAIL reset_boot pc=%0d got=%h exp=%h", a, current_instruction, model[a]);
            end
        end
    endtask

    task automatic test_boot_image();
        for (int a = 0; a < DEPTH; a++) begin
            pc = 8'(a);
            #1;
            n_checks++;
            if (current_instruction !== boot[a]) begin
                n_fail++;
                $display("FAIL boot_image pc=%0d got=%h exp=%h", a, current_instruction, boot[a]);
            end
        end
    endtask

    task automatic test_out_of_range_read();
        logic [7:0] pcs [3];
        pcs[0] = 8'd10; pcs[1] = 8'd255; pcs[2] = 8'd128;
        for (int i = 0; i < 3; i++) begin
            pc = pcs[i];
            #1;
            n_checks++;
            if (current_instruction !== NOP) begin
                n_fail++;
                $display("FAIL oor_read pc=%0d got=%h exp=%h", pcs[i], current_instruction, NOP);
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        model_write(a, d);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_write_same_addr();
        @(negedge clk);
        pc = 8'd2; wr_en = 1'b1; wr_addr = 8'd2; wr_data = 16'hABCD;
        #1;
        n_checks++;
        if (current_instruction !== model[2]) begin
            n_fail++;
            $display("FAIL write_before_edge got=%h exp=%h", current_instruction, model[2]);
        end
        @(posedge clk);
        model_write(8'd2, 16'hABCD);
        #1;
        wr_en = 1'b0;
        n_checks++;
        if (current_instruction !== 16'hABCD) begin
            n_fail++;
            $display("FAIL write_after_edge got=%h exp=%h", current_instruction, 16'hABCD);
        end
        pc = 8'd3;
        #1;
        n_checks++;
        if (current_instruction !== 16'h4430) begin
            n_fail++;
            $display("FAIL write_neighbour got=%h exp=%h", current_instruction, 16'h4430);
        end
    endtask

    task automatic test_write_dropped();
        do_write(8'd12, 16'hFFFF);
        do_write(8'd255, 16'hEEEE);
        for (int a = 0; a < 16; a++) begin
            pc = 8'(a);
            #1;
            n_checks++;
            if (current_instruction !== model[a]) begin
                n_fail++;
                $display("FAIL drop_write pc=%0d got=%h exp=%h", a, current_instruction, model[a]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_write(8'd0, 16'h1234);
        pc = 8'd0;
        @(negedge clk);
        n_checks++;
        if (current_instruction !== 16'h1234) begin
            n_fail++;
            $display("FAIL async_pre got=%h exp=%h", current_instruction, 16'h1234);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (current_instruction !== 16'h1105) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", current_instruction, 16'h1105);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_blocks_write();
        do_write(8'd1, 16'h7777);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        wr_en = 1'b1; wr_addr = 8'd1; wr_data = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        pc = 8'd1;
        #1;
        n_checks++;
        if (current_instruction !== 16'h1203) begin
            n_fail++;
            $display("FAIL reset_blocks_write got=%h exp=%h", current_instruction, 16'h1203);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [15:0] d;
        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 15));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d);
            pc = 8'($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, 255));
            #1;
            n_checks++;
            if (current_instruction !== model[pc]) begin
                n_fail++;
                $display("FAIL random pc=%0d got=%h exp=%h", pc, current_instruction, model[pc]);
            end
        end
    endtask

    initial begin
        boot[0] = 16'h1105; boot[1] = 16'h1203; boot[2] = 16'h3312;
        boot[3] = 16'h4430; boot[4] = 16'h5140; boot[5] = 16'h6200;
        boot[6] = 16'h7105; boot[7] = 16'h8008; boot[8] = 16'h9000;
        boot[9] = 16'hF000;

        test_reset();
        test_boot_image();
        test_out_of_range_read();
        test_write_same_addr();
        test_write_dropped();
        test_async_reset();
        test_boot_image();
        test_reset_blocks_write();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
